// File: rtl/imem_bus_pkg.sv
// Shared types and size helpers for the imem bus-side line-refill responder.
// Supplies fallback values for IMEM_LINE / IMEM_BLK_LEN when the imem build does not define them.

`ifndef IMEM_LINE
`define IMEM_LINE 256
`endif
`ifndef IMEM_BLK_LEN
`define IMEM_BLK_LEN 26
`endif

package imem_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StGap
    } state_t;

    // Words per line.
    function automatic int unsigned calc_beats(input int unsigned line_w,
                                               input int unsigned word_w);
        return line_w / word_w;
    endfunction

    // Beat index width; at least one bit so a single-beat line still has a counter.
    function automatic int unsigned calc_beat_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/imem_line_asm.sv
// Line assembler: beat counter plus line register.
// clear_i zeroes both; load_i writes word_i at the current beat and advances the counter
// unless it is already on the last beat (the counter never wraps within a line).

module imem_line_asm
    import imem_bus_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned BEATS  = 4,
    localparam int unsigned BEAT_W = calc_beat_w(BEATS),
    localparam int unsigned LINE_W = BEATS * WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic [BEAT_W-1:0] cnt_next_o,
    output logic              last_o,
    output logic [LINE_W-1:0] line_o,
    output logic [LINE_W-1:0] line_next_o
);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    assign last_o = (cnt_q == BEAT_W'(BEATS - 1));

    // Next counter/line: clear on a new request, else merge the incoming word at the beat slot.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clear_i) begin
            cnt_d  = '0;
            line_d = '0;
        end else if (load_i) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (cnt_q == BEAT_W'(i)) begin
                    line_d[i*WORD_W +: WORD_W] = word_i;
                end
            end
            if (!last_o) begin
                cnt_d = cnt_q + BEAT_W'(1);
            end
        end
    end

    // Counter and line state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign cnt_next_o  = cnt_d;
    assign line_o      = line_q;
    assign line_next_o = line_d;

endmodule

// File: rtl/imem_bus_resp.sv
// Bus-side responder for the imem line-refill port. Fetches a line as BEATS sequential word
// reads from a narrower memory, assembles it and returns it with a one-cycle b_dv_i strobe.
// Optional feature macro: IMEM_BUS_RESP_LBUF_EN adds a one-entry last-line buffer that answers
// a repeat request for the most recently refilled line without touching memory.

module imem_bus_resp
    import imem_bus_pkg::*;
#(
    parameter int unsigned LINE_W = `IMEM_LINE,
    parameter int unsigned BLK_W  = `IMEM_BLK_LEN,
    parameter int unsigned WORD_W = 64,
    localparam int unsigned BEATS  = calc_beats(LINE_W, WORD_W),
    localparam int unsigned BEAT_W = calc_beat_w(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    b_rd_i,
    input  logic [BLK_W-1:0]        b_addr_i,
    output logic [LINE_W-1:0]       b_data_i,
    output logic                    b_dv_i,
    output logic                    m_rd,
    output logic [BLK_W+BEAT_W-1:0] m_addr,
    input  logic [WORD_W-1:0]       m_data,
    input  logic                    m_dv
);

    state_t            state_q, state_d;
    logic [BLK_W-1:0]  addr_q, addr_d;

    logic              asm_clear;
    logic              asm_load;
    logic [BEAT_W-1:0] asm_cnt;
    logic [BEAT_W-1:0] asm_cnt_next;
    logic              asm_last;
    logic [LINE_W-1:0] asm_line;
    logic [LINE_W-1:0] asm_line_next;

    logic              lbuf_hit;
    logic [LINE_W-1:0] resp_line;

    imem_line_asm #(
        .WORD_W (WORD_W),
        .BEATS  (BEATS)
    ) u_line_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (asm_clear),
        .load_i      (asm_load),
        .word_i      (m_data),
        .cnt_o       (asm_cnt),
        .cnt_next_o  (asm_cnt_next),
        .last_o      (asm_last),
        .line_o      (asm_line),
        .line_next_o (asm_line_next)
    );

`ifdef IMEM_BUS_RESP_LBUF_EN
    logic              lbuf_valid_q;
    logic [BLK_W-1:0]  lbuf_tag_q;
    logic [LINE_W-1:0] lbuf_line_q;

    assign lbuf_hit  = (state_q == StIdle) && b_rd_i && lbuf_valid_q && (b_addr_i == lbuf_tag_q);
    assign resp_line = lbuf_hit ? lbuf_line_q : asm_line_next;

    // Capture each completed refill; an aborted refill never reaches the last beat load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lbuf_valid_q <= 1'b0;
            lbuf_tag_q   <= '0;
            lbuf_line_q  <= '0;
        end else if (asm_load && asm_last) begin
            lbuf_valid_q <= 1'b1;
            lbuf_tag_q   <= addr_q;
            lbuf_line_q  <= asm_line_next;
        end
    end
`else
    assign lbuf_hit  = 1'b0;
    assign resp_line = asm_line_next;
`endif

    // Next-state logic; m_dv only matters in StWait, b_rd_i only in StIdle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
        asm_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (b_rd_i) begin
                    addr_d = b_addr_i;
                    if (lbuf_hit) begin
                        state_d = StResp;
                    end else begin
                        asm_clear = 1'b1;
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (m_dv) begin
                    asm_load = 1'b1;
                    state_d  = asm_last ? StResp : StIssue;
                end
            end
            StResp:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, address latch and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            m_rd     <= 1'b0;
            m_addr   <= '0;
            b_dv_i   <= 1'b0;
            b_data_i <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            m_rd     <= (state_d == StIssue);
            m_addr   <= (state_d == StIssue) ? {addr_d, asm_cnt_next} : '0;
            b_dv_i   <= (state_d == StResp);
            b_data_i <= (state_d == StResp) ? resp_line : '0;
        end
    end

    // asm_cnt and asm_line are observed only through their next-state views.
    logic unused_asm;
    assign unused_asm = ^{asm_cnt, asm_line};

endmodule
